// File: rtl/ng_cnt_sched.sv
// Counter-increment scheduler: captures scaler/overflow pulses as pending requests and
// serves them one at a time to PROC over a REQ/ACK handshake, with timeout and lost-pulse flags.
module ng_cnt_sched #(
  parameter int unsigned TO_CYC = 255
) (
  input  logic       CLK1,
  input  logic       NPURST,
  input  logic       F10X,
  input  logic       F13X,
  input  logic       F17X,
  input  logic       T1_OVF,
  input  logic       CTR_ACK,
  input  logic       MISS_CLR,
  output logic       CTR_REQ,
  output logic [2:0] CTR_SEL,
  output logic [4:0] PEND,
  output logic [4:0] MISS,
  output logic       ERR_TO,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

  state_t     state_q;
  logic       req_q;
  logic       busy_q;
  logic [2:0] sel_q;
  logic [4:0] pend_q;
  logic [4:0] miss_q;
  logic       err_q;
  logic [7:0] to_cnt_q;

  logic [4:0] src;
  logic       in_req;
  logic       timeout_hit;
  logic       req_done;
  logic [4:0] clr_mask;
  logic [4:0] pend_d;
  logic [4:0] miss_d;
  logic       err_d;
  logic [2:0] win;

  // Source vector indexed like CTR_SEL; F10X feeds both TIME1 and TIME3.
  assign src         = {F17X, F13X, F10X, F10X, T1_OVF};
  assign in_req      = (state_q == S_REQ);
  assign timeout_hit = (to_cnt_q == TO_LAST);
  assign req_done    = in_req && (CTR_ACK || timeout_hit);

  always_comb begin
    clr_mask = 5'b00000;
    if (req_done) begin
      clr_mask = 5'b00001 << sel_q;
    end
    // A new pulse on the clearing edge re-arms the bit rather than counting as lost.
    pend_d = (pend_q & ~clr_mask) | src;
    miss_d = (MISS_CLR ? 5'b00000 : miss_q) | (src & pend_q & ~clr_mask);
    err_d  = (MISS_CLR ? 1'b0 : err_q) | (in_req && !CTR_ACK && timeout_hit);
  end

  always_comb begin
    win = 3'd4;
    if (pend_q[0])      win = 3'd0;
    else if (pend_q[1]) win = 3'd1;
    else if (pend_q[2]) win = 3'd2;
    else if (pend_q[3]) win = 3'd3;
  end

  always_ff @(posedge CLK1 or negedge NPURST) begin
    if (!NPURST) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      sel_q    <= 3'd0;
      pend_q   <= 5'b00000;
      miss_q   <= 5'b00000;
      err_q    <= 1'b0;
      to_cnt_q <= 8'd0;
    end else begin
      pend_q <= pend_d;
      miss_q <= miss_d;
      err_q  <= err_d;
      unique case (state_q)
        S_IDLE: begin
          if (|pend_q) begin
            state_q  <= S_REQ;
            sel_q    <= win;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            to_cnt_q <= 8'd0;
          end
        end
        S_REQ: begin
          if (req_done) begin
            state_q <= S_GAP;
            req_q   <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          // Forced idle cycle between consecutive requests.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          sel_q   <= 3'd0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          sel_q   <= 3'd0;
        end
      endcase
    end
  end

  assign CTR_REQ = req_q;
  assign CTR_SEL = sel_q;
  assign PEND    = pend_q;
  assign MISS    = miss_q;
  assign ERR_TO  = err_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_ng_cnt_sched.sv
// Directed self-checking bench for ng_cnt_sched; a second instance with TO_CYC=4 covers timeout.
module tb_ng_cnt_sched;

  logic CLK1 = 1'b0;
  logic NPURST = 1'b0;
  logic F10X = 1'b0, F13X = 1'b0, F17X = 1'b0, T1_OVF = 1'b0;
  logic CTR_ACK = 1'b0, MISS_CLR = 1'b0;

  logic       req_a, err_a, busy_a, req_b, err_b, busy_b;
  logic [2:0] sel_a, sel_b;
  logic [4:0] pend_a, miss_a, pend_b, miss_b;
  logic [15:0] st, st4, exp;

  int checks = 0;
  int errors = 0;

  always #5 CLK1 = ~CLK1;

  ng_cnt_sched u_dut (
    .CLK1(CLK1), .NPURST(NPURST), .F10X(F10X), .F13X(F13X), .F17X(F17X),
    .T1_OVF(T1_OVF), .CTR_ACK(CTR_ACK), .MISS_CLR(MISS_CLR),
    .CTR_REQ(req_a), .CTR_SEL(sel_a), .PEND(pend_a), .MISS(miss_a),
    .ERR_TO(err_a), .BUSY(busy_a)
  );

  ng_cnt_sched #(.TO_CYC(4)) u_dut4 (
    .CLK1(CLK1), .NPURST(NPURST), .F10X(F10X), .F13X(F13X), .F17X(F17X),
    .T1_OVF(T1_OVF), .CTR_ACK(CTR_ACK), .MISS_CLR(MISS_CLR),
    .CTR_REQ(req_b), .CTR_SEL(sel_b), .PEND(pend_b), .MISS(miss_b),
    .ERR_TO(err_b), .BUSY(busy_b)
  );

  // Status word layout: {REQ, SEL[2:0], PEND[4:0], MISS[4:0], ERR_TO, BUSY}
  assign st  = {req_a, sel_a, pend_a, miss_a, err_a, busy_a};
  assign st4 = {req_b, sel_b, pend_b, miss_b, err_b, busy_b};

  function automatic logic [15:0] pk(input logic r, input logic [2:0] s, input logic [4:0] p,
                                     input logic [4:0] m, input logic e, input logic b);
    return {r, s, p, m, e, b};
  endfunction

  task automatic tick();
    @(posedge CLK1);
    #1;
  endtask

  task automatic do_reset();
    {F10X, F13X, F17X, T1_OVF, CTR_ACK, MISS_CLR} = '0;
    NPURST = 1'b0;
    repeat (2) @(posedge CLK1);
    #1;
    NPURST = 1'b1;
  endtask

  task automatic test_reset();
    {F10X, F13X, F17X, T1_OVF, CTR_ACK, MISS_CLR} = '0;
    NPURST = 1'b0;
    #3;
    checks++; if (st !== 16'd0) begin errors++; $display("FAIL reset_held: got %b want %b", st, 16'd0); end
    checks++; if (st4 !== 16'd0) begin errors++; $display("FAIL reset_held4: got %b want %b", st4, 16'd0); end
    @(posedge CLK1); #1;
    NPURST = 1'b1;
    tick();
    checks++; if (st !== 16'd0) begin errors++; $display("FAIL reset_release: got %b want %b", st, 16'd0); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    F13X = 1'b1; tick();
    exp = pk(1'b0, 3'd0, 5'b01000, 5'b0, 1'b0, 1'b0);
    checks++; if (st !== exp) begin errors++; $display("FAIL single_capture: got %b want %b", st, exp); end
    F13X = 1'b0; tick();
    exp = pk(1'b1, 3'd3, 5'b01000, 5'b0, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL single_grant: got %b want %b", st, exp); end
    tick(); tick();
    checks++; if (st !== exp) begin errors++; $display("FAIL single_hold: got %b want %b", st, exp); end
    CTR_ACK = 1'b1; tick();
    exp = pk(1'b0, 3'd3, 5'b00000, 5'b0, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL single_ack: got %b want %b", st, exp); end
    CTR_ACK = 1'b0; tick();
    exp = pk(1'b0, 3'd0, 5'b00000, 5'b0, 1'b0, 1'b0);
    checks++; if (st !== exp) begin errors++; $display("FAIL single_idle: got %b want %b", st, exp); end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    logic [4:0] before_t [3];
    logic [4:0] after_t [3];
    before_t = '{5'b00111, 5'b00110, 5'b00100};
    after_t  = '{5'b00110, 5'b00100, 5'b00000};
    do_reset();
    CTR_ACK = 1'b1; F10X = 1'b1; T1_OVF = 1'b1; tick();
    exp = pk(1'b0, 3'd0, 5'b00111, 5'b0, 1'b0, 1'b0);
    checks++; if (st !== exp) begin errors++; $display("FAIL b2b_capture: got %b want %b", st, exp); end
    F10X = 1'b0; T1_OVF = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = pk(1'b1, 3'(i), before_t[i], 5'b0, 1'b0, 1'b1);
      checks++; if (st !== exp) begin errors++; $display("FAIL b2b_grant%0d: got %b want %b", i, st, exp); end
      tick();
      exp = pk(1'b0, 3'(i), after_t[i], 5'b0, 1'b0, 1'b1);
      checks++; if (st !== exp) begin errors++; $display("FAIL b2b_gap%0d: got %b want %b", i, st, exp); end
      tick();
      exp = pk(1'b0, 3'd0, after_t[i], 5'b0, 1'b0, 1'b0);
      checks++; if (st !== exp) begin errors++; $display("FAIL b2b_idle%0d: got %b want %b", i, st, exp); end
      $display("back_to_back grant %0d served", i);
    end
    CTR_ACK = 1'b0;
  endtask

  task automatic test_miss();
    do_reset();
    F10X = 1'b1; T1_OVF = 1'b1; tick();
    F10X = 1'b0; T1_OVF = 1'b0; tick();
    exp = pk(1'b1, 3'd0, 5'b00111, 5'b0, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL miss_grant: got %b want %b", st, exp); end
    F10X = 1'b1; tick();
    exp = pk(1'b1, 3'd0, 5'b00111, 5'b00110, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL miss_set: got %b want %b", st, exp); end
    MISS_CLR = 1'b1; tick();
    checks++; if (st !== exp) begin errors++; $display("FAIL miss_set_over_clr: got %b want %b", st, exp); end
    F10X = 1'b0; tick();
    exp = pk(1'b1, 3'd0, 5'b00111, 5'b0, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL miss_clear: got %b want %b", st, exp); end
    MISS_CLR = 1'b0;
    $display("test_miss done");
  endtask

  task automatic test_ack_collision();
    do_reset();
    F17X = 1'b1; tick();
    F17X = 1'b0; tick();
    exp = pk(1'b1, 3'd4, 5'b10000, 5'b0, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL coll_grant: got %b want %b", st, exp); end
    F17X = 1'b1; CTR_ACK = 1'b1; tick();
    exp = pk(1'b0, 3'd4, 5'b10000, 5'b0, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL coll_setwins: got %b want %b", st, exp); end
    F17X = 1'b0; CTR_ACK = 1'b0; tick();
    tick();
    exp = pk(1'b1, 3'd4, 5'b10000, 5'b0, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL coll_regrant: got %b want %b", st, exp); end
    CTR_ACK = 1'b1; tick();
    exp = pk(1'b0, 3'd4, 5'b00000, 5'b0, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL coll_final_ack: got %b want %b", st, exp); end
    CTR_ACK = 1'b0;
    $display("test_ack_collision done");
  endtask

  task automatic test_timeout();
    do_reset();
    F13X = 1'b1; tick();
    F13X = 1'b0;
    exp = pk(1'b1, 3'd3, 5'b01000, 5'b0, 1'b0, 1'b1);
    for (int j = 1; j <= 4; j++) begin
      tick();
      checks++; if (st4 !== exp) begin errors++; $display("FAIL to_req_cycle%0d: got %b want %b", j, st4, exp); end
    end
    tick();
    exp = pk(1'b0, 3'd3, 5'b00000, 5'b0, 1'b1, 1'b1);
    checks++; if (st4 !== exp) begin errors++; $display("FAIL to_drop: got %b want %b", st4, exp); end
    tick();
    exp = pk(1'b0, 3'd0, 5'b00000, 5'b0, 1'b1, 1'b0);
    checks++; if (st4 !== exp) begin errors++; $display("FAIL to_idle: got %b want %b", st4, exp); end
    MISS_CLR = 1'b1; tick();
    MISS_CLR = 1'b0;
    checks++; if (st4 !== 16'd0) begin errors++; $display("FAIL to_clr: got %b want %b", st4, 16'd0); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    int req_seen = 0;
    do_reset();
    F10X = 1'b1; tick();
    F10X = 1'b0; tick();
    CTR_ACK = 1'b1; tick();
    CTR_ACK = 1'b0; tick(); tick();
    exp = pk(1'b1, 3'd2, 5'b00100, 5'b0, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL mid_sel2: got %b want %b", st, exp); end
    F10X = 1'b1; tick();
    F10X = 1'b0; CTR_ACK = 1'b1; F13X = 1'b1; F17X = 1'b1; tick();
    CTR_ACK = 1'b0; F13X = 1'b0; F17X = 1'b0; tick(); tick();
    exp = pk(1'b1, 3'd1, 5'b11010, 5'b00100, 1'b0, 1'b1);
    checks++; if (st !== exp) begin errors++; $display("FAIL mid_setup: got %b want %b", st, exp); end
    #2 NPURST = 1'b0;
    #1;
    checks++; if (st !== 16'd0) begin errors++; $display("FAIL mid_async_clear: got %b want %b", st, 16'd0); end
    @(negedge CLK1);
    NPURST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (req_a) req_seen++;
    end
    checks++; if (req_seen !== 0) begin errors++; $display("FAIL mid_no_req: got %0d want 0", req_seen); end
    checks++; if (st !== 16'd0) begin errors++; $display("FAIL mid_quiet: got %b want %b", st, 16'd0); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_miss();
    test_ack_collision();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
